// File: rtl/uart_rx_ovs_pkg.sv
// Purpose : shared types, constants and helpers for the oversampling UART receiver.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package uart_rx_ovs_pkg;

  localparam int OVS      = 16;
  localparam int DATA_MAX = 9;

  // Sample-counter landmarks within one bit period: three vote samples
  // centred on mid-bit, and the last tick of the bit.
  localparam logic [3:0] SCNT_S0   = 4'(OVS / 2 - 1);
  localparam logic [3:0] SCNT_S1   = 4'(OVS / 2);
  localparam logic [3:0] SCNT_MID  = 4'(OVS / 2 + 1);
  localparam logic [3:0] SCNT_LAST = 4'(OVS - 1);

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } ParityMode_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } RxState_t;

  typedef struct packed {
    logic                ferr;
    logic                perr;
    logic [DATA_MAX-1:0] data;
  } RxEntry_t;

  // 2-of-3 majority.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Encoding 3 is a second spelling of "no parity".
  function automatic ParityMode_t parity_mode(input logic [1:0] cfg);
    case (cfg)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  // Data bits per frame; nine-bit mode only exists when the datapath is wide enough.
  function automatic logic [3:0] frame_len(input logic [1:0] bits, input logic nine,
                                           input int data_w);
    if (nine && data_w >= 9) return 4'd9;
    return {2'b00, bits} + 4'd5;
  endfunction

endpackage

// File: rtl/uart_rx_ovs_if.sv
// Purpose : receive-FIFO read port between the UART receiver and its consumer.
// Latency : n/a (wires only).
// Backpressure: consumer holds rx_ready low to leave the head entry in place.
//   rx_data  head data, right-aligned     rx_perr/rx_ferr  head error tags
//   rx_valid FIFO not empty               rx_ready         pop when valid
interface uart_rx_ovs_if #(
  parameter int DATA_W = 9
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_perr;
  logic              rx_ferr;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, rx_perr, rx_ferr, rx_valid, input rx_ready);
  modport slave  (input rx_data, rx_perr, rx_ferr, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_ovs_fifo.sv
// Purpose : generic synchronous FIFO with occupancy output and flush.
// Latency : a push is visible at the head on the next cycle.
// Backpressure: push while full is dropped (o_drop) unless a pop is accepted in the same cycle.
//   clk, rst_n         clock, async active-low reset
//   i_flush            empty the FIFO; beats same-cycle push/pop
//   i_push/i_push_dat  write request and data
//   i_pop              read request (ignored when empty)
//   o_head_dat         head entry, zero when empty
//   o_level/o_full/o_empty/o_drop  occupancy and status
module uart_rx_ovs_fifo #(
  parameter int data_size   = 11,
  parameter int buffer_size = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [data_size-1:0]         i_push_dat,
  input  logic                         i_pop,
  output logic [data_size-1:0]         o_head_dat,
  output logic [$clog2(buffer_size):0] o_level,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_drop
);
  localparam int AW = $clog2(buffer_size);
  localparam int LW = AW + 1;

  logic [data_size-1:0] r_mem [buffer_size];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_level == LW'(buffer_size));
  assign w_empty   = (r_level == '0);
  assign w_do_pop  = i_pop && !w_empty && !i_flush;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);

  assign o_drop     = i_push && !i_flush && w_full && !w_do_pop;
  assign o_level    = r_level;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_head_dat = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset; the head mux hides stale contents while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// Purpose : 16x-oversampling UART receiver, runtime frame format, RX FIFO with error tags, RTS.
// Latency : character at FIFO head two cycles after the final stop-bit vote.
// Backpressure: rts_n rises at the RTS threshold; frames arriving to a full FIFO are dropped (overrun).
//   clk, rst_n, tick16, rx        clock, async reset, 16x baud enable, raw serial input
//   cfg_en/cfg_data_bits/cfg_nine/cfg_parity/cfg_stop2  frame format and enable
//   flush, err_clr                FIFO clear, sticky status clear
//   rx_if (master)                FIFO head: rx_data/rx_perr/rx_ferr/rx_valid, rx_ready
//   rts_n, level, full, empty, overrun, break_det, wakeup  status
module uart_rx_ovs
  import uart_rx_ovs_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_THRESH = FIFO_DEPTH - 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick16,
  input  logic                        rx,
  output logic                        rts_n,
  input  logic                        cfg_en,
  input  logic [1:0]                  cfg_data_bits,
  input  logic                        cfg_nine,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  input  logic                        flush,
  input  logic                        err_clr,
  uart_rx_ovs_if.master               rx_if,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        full,
  output logic                        empty,
  output logic                        overrun,
  output logic                        break_det,
  output logic                        wakeup
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = DATA_W + 2;

  // Two-flop synchroniser; idles high like the line.
  logic r_rx_s1;
  logic r_rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  RxState_t          r_state;
  logic [3:0]        r_scnt;
  logic [3:0]        r_bcnt;
  logic              r_smp0;
  logic              r_smp1;
  logic [DATA_W-1:0] r_data;
  logic              r_perr;
  logic              r_ferr;
  logic              r_par_smp;
  logic              r_stop_idx;
  logic              r_push;
  logic              r_brk;
  RxEntry_t          r_entry;

  logic              w_rx;
  logic              w_vote;
  logic [3:0]        w_len;
  ParityMode_t       w_par;
  logic              w_par_en;
  logic              w_ferr_fin;
  logic              w_last_stop;

  assign w_rx        = r_rx_s2;
  // Only meaningful on the SCNT_MID tick, when the two earlier samples are held.
  assign w_vote      = maj3(r_smp0, r_smp1, w_rx);
  assign w_len       = frame_len(cfg_data_bits, cfg_nine, DATA_W);
  assign w_par       = parity_mode(cfg_parity);
  assign w_par_en    = (w_par != PAR_NONE);
  assign w_ferr_fin  = r_ferr | ~w_vote;
  assign w_last_stop = !cfg_stop2 || r_stop_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RX_IDLE;
      r_scnt     <= '0;
      r_bcnt     <= '0;
      r_smp0     <= 1'b1;
      r_smp1     <= 1'b1;
      r_data     <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_par_smp  <= 1'b0;
      r_stop_idx <= 1'b0;
      r_push     <= 1'b0;
      r_brk      <= 1'b0;
      r_entry    <= '0;
    end else begin
      r_push <= 1'b0;
      r_brk  <= 1'b0;
      if (!cfg_en) begin
        // Disabling drops any partial frame; nothing is pushed.
        r_state <= RX_IDLE;
        r_scnt  <= '0;
        r_bcnt  <= '0;
      end else if (tick16) begin
        if (r_scnt == SCNT_S0) r_smp0 <= w_rx;
        if (r_scnt == SCNT_S1) r_smp1 <= w_rx;
        r_scnt <= r_scnt + 4'd1;
        case (r_state)
          RX_IDLE: begin
            r_scnt <= '0;
            if (!w_rx) begin
              r_state    <= RX_START;
              r_bcnt     <= '0;
              r_data     <= '0;
              r_perr     <= 1'b0;
              r_ferr     <= 1'b0;
              r_par_smp  <= 1'b0;
              r_stop_idx <= 1'b0;
            end
          end
          RX_START: begin
            if (r_scnt == SCNT_MID && w_vote) begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              r_state <= RX_IDLE;
              r_scnt  <= '0;
            end else if (r_scnt == SCNT_LAST) begin
              r_state <= RX_DATA;
              r_bcnt  <= '0;
            end
          end
          RX_DATA: begin
            if (r_scnt == SCNT_MID) r_data <= r_data | (DATA_W'(w_vote) << r_bcnt);
            if (r_scnt == SCNT_LAST) begin
              if (r_bcnt == w_len - 4'd1) r_state <= w_par_en ? RX_PARITY : RX_STOP;
              else                        r_bcnt  <= r_bcnt + 4'd1;
            end
          end
          RX_PARITY: begin
            if (r_scnt == SCNT_MID) begin
              r_par_smp <= w_vote;
              // Even: any set XOR is an error; odd: a clear XOR is.
              r_perr    <= (^r_data) ^ w_vote ^ (w_par == PAR_ODD);
            end
            if (r_scnt == SCNT_LAST) r_state <= RX_STOP;
          end
          RX_STOP: begin
            if (r_scnt == SCNT_MID) begin
              if (!w_last_stop) begin
                r_ferr <= w_ferr_fin;
              end else begin
                // Push at the final stop vote, then go straight to IDLE so a
                // short stop bit still lets the next start edge be caught.
                r_push       <= 1'b1;
                r_entry.ferr <= w_ferr_fin;
                r_entry.perr <= r_perr;
                r_entry.data <= DATA_MAX'(r_data);
                r_brk        <= (r_data == '0) && (!w_par_en || !r_par_smp) && w_ferr_fin;
                r_state      <= RX_IDLE;
                r_scnt       <= '0;
              end
            end else if (r_scnt == SCNT_LAST) begin
              r_stop_idx <= 1'b1;
            end
          end
          default: begin
            r_state <= RX_IDLE;
            r_scnt  <= '0;
          end
        endcase
      end
    end
  end

  assign wakeup = (r_state != RX_IDLE);

  logic [EW-1:0] w_push_dat;
  logic [EW-1:0] w_head;
  logic [LW-1:0] w_level;
  logic          w_full;
  logic          w_empty;
  logic          w_drop;
  logic          w_pop;

  assign w_push_dat = {r_entry.ferr, r_entry.perr, r_entry.data[DATA_W-1:0]};
  assign w_pop      = !w_empty && rx_if.rx_ready;

  uart_rx_ovs_fifo #(
    .data_size   (EW),
    .buffer_size (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_push     (r_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_level    (w_level),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_drop     (w_drop)
  );

  assign rx_if.rx_data  = w_head[DATA_W-1:0];
  assign rx_if.rx_perr  = w_head[DATA_W];
  assign rx_if.rx_ferr  = w_head[DATA_W+1];
  assign rx_if.rx_valid = !w_empty;
  assign level          = w_level;
  assign full           = w_full;
  assign empty          = w_empty;

  logic r_overrun;
  logic r_break;
  logic r_rts_n;

  // Set beats a same-cycle clear so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
      r_break   <= 1'b0;
      r_rts_n   <= 1'b1;
    end else begin
      r_overrun <= (r_push && w_drop) || (r_overrun && !err_clr);
      r_break   <= (r_push && r_brk)  || (r_break && !err_clr);
      r_rts_n   <= (w_level >= LW'(RTS_THRESH));
    end
  end

  assign overrun   = r_overrun;
  assign break_det = r_break;
  assign rts_n     = r_rts_n;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Purpose : directed self-checking bench for uart_rx_ovs.
// Latency : n/a.
// Backpressure: bench drives rx_ready directly.
module tb_uart_rx_ovs;
  localparam int DATA_W     = 9;
  localparam int FIFO_DEPTH = 16;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk           = 1'b0;
  logic          rst_n         = 1'b0;
  logic          tick16        = 1'b0;
  logic          rx            = 1'b1;
  logic          cfg_en        = 1'b0;
  logic [1:0]    cfg_data_bits = 2'd3;
  logic          cfg_nine      = 1'b0;
  logic [1:0]    cfg_parity    = 2'd0;
  logic          cfg_stop2     = 1'b0;
  logic          flush         = 1'b0;
  logic          err_clr       = 1'b0;
  logic          rts_n;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          overrun;
  logic          break_det;
  logic          wakeup;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_ovs_if #(.DATA_W(DATA_W)) rxq ();

  uart_rx_ovs #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick16        (tick16),
    .rx            (rx),
    .rts_n         (rts_n),
    .cfg_en        (cfg_en),
    .cfg_data_bits (cfg_data_bits),
    .cfg_nine      (cfg_nine),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .flush         (flush),
    .err_clr       (err_clr),
    .rx_if         (rxq),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .overrun       (overrun),
    .break_det     (break_det),
    .wakeup        (wakeup)
  );

  always #5 clk = ~clk;

  // One tick16 pulse every third clock.
  initial begin
    forever begin
      repeat (2) @(posedge clk);
      #1 tick16 = 1'b1;
      @(posedge clk);
      #1 tick16 = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns #1 after the next clock edge on which tick16 is high.
  task automatic wait_tick();
    int guard;
    guard = 0;
    @(posedge clk);
    while (tick16 !== 1'b1 && guard < 16) begin
      @(posedge clk);
      guard++;
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (16) wait_tick();
  endtask

  task automatic pop();
    rxq.rx_ready = 1'b1;
    @(posedge clk);
    #1 rxq.rx_ready = 1'b0;
  endtask

  // par: 0 none, 1 even, 2 odd. At data bit probe_bit, mid-bit, wakeup is
  // checked and optionally a one-cycle flush is issued.
  task automatic send_frame(input logic [8:0] d, input int nbits, input int par,
                            input bit flip_par, input int nstop, input bit stop2_low,
                            input int probe_bit, input bit do_flush);
    logic p;
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (i == probe_bit) begin
        rx = d[i];
        repeat (8) wait_tick();
        check_val("wakeup_mid", wakeup, 1);
        if (do_flush) begin
          flush = 1'b1;
          @(posedge clk);
          #1 flush = 1'b0;
          check_val("flush_level", level, 0);
          check_val("flush_empty", empty, 1);
        end
        repeat (8) wait_tick();
      end else begin
        send_bit(d[i]);
      end
    end
    p = 1'b0;
    for (int i = 0; i < nbits; i++) p = p ^ d[i];
    if (par == 1)      send_bit(p ^ flip_par);
    else if (par == 2) send_bit(~p ^ flip_par);
    send_bit(1'b1);
    if (nstop == 2) send_bit(~stop2_low);
  endtask

  initial begin
    rxq.rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rts_n", rts_n, 1);
    check_val("rst_valid", rxq.rx_valid, 0);
    check_val("rst_data", rxq.rx_data, 0);
    check_val("rst_perr", rxq.rx_perr, 0);
    check_val("rst_ferr", rxq.rx_ferr, 0);
    check_val("rst_level", level, 0);
    check_val("rst_empty", empty, 1);
    check_val("rst_full", full, 0);
    check_val("rst_overrun", overrun, 0);
    check_val("rst_break", break_det, 0);
    check_val("rst_wakeup", wakeup, 0);

    rst_n  = 1'b1;
    cfg_en = 1'b1;
    repeat (40) wait_tick();

    // 8N1, 0xA5
    check_val("a5_wake_before", wakeup, 0);
    send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b0, 4, 1'b0);
    check_val("a5_wake_after", wakeup, 0);
    check_val("a5_level", level, 1);
    check_val("a5_valid", rxq.rx_valid, 1);
    check_val("a5_data", rxq.rx_data, 9'h0A5);
    check_val("a5_perr", rxq.rx_perr, 0);
    check_val("a5_ferr", rxq.rx_ferr, 0);
    pop();
    check_val("a5_popped", empty, 1);

    // 7E2: bad parity, then low second stop bit
    cfg_data_bits = 2'd2;
    cfg_parity    = 2'd1;
    cfg_stop2     = 1'b1;
    send_frame(9'h041, 7, 1, 1'b1, 2, 1'b0, -1, 1'b0);
    send_frame(9'h041, 7, 1, 1'b0, 2, 1'b1, -1, 1'b0);
    rx = 1'b1;
    repeat (40) wait_tick();
    check_val("7e2_level", level, 2);
    check_val("7e2_p_data", rxq.rx_data, 9'h041);
    check_val("7e2_p_perr", rxq.rx_perr, 1);
    check_val("7e2_p_ferr", rxq.rx_ferr, 0);
    pop();
    check_val("7e2_f_data", rxq.rx_data, 9'h041);
    check_val("7e2_f_perr", rxq.rx_perr, 0);
    check_val("7e2_f_ferr", rxq.rx_ferr, 1);
    pop();
    check_val("7e2_empty", empty, 1);

    cfg_data_bits = 2'd3;
    cfg_parity    = 2'd0;
    cfg_stop2     = 1'b0;

    // Start-bit glitch of 4 ticks
    rx = 1'b0;
    repeat (4) wait_tick();
    rx = 1'b1;
    check_val("glitch_wake_in", wakeup, 1);
    repeat (32) wait_tick();
    check_val("glitch_wake_out", wakeup, 0);
    check_val("glitch_level", level, 0);

    // Receiver disabled mid-frame
    send_bit(1'b0);
    rx = 1'b1;
    repeat (8) wait_tick();
    check_val("dis_wake_in", wakeup, 1);
    cfg_en = 1'b0;
    @(posedge clk);
    #1 check_val("dis_wake_off", wakeup, 0);
    cfg_en = 1'b1;
    repeat (160) wait_tick();
    check_val("dis_level", level, 0);
    check_val("dis_wake_end", wakeup, 0);

    // Fill past capacity with no reader
    for (int k = 0; k < FIFO_DEPTH + 1; k++) begin
      send_frame(9'(16 + k), 8, 0, 1'b0, 1, 1'b0, -1, 1'b0);
      if (k == 12) begin
        check_val("fill13_level", level, 13);
        check_val("fill13_rts_n", rts_n, 0);
      end
      if (k == 13) begin
        check_val("fill14_level", level, 14);
        check_val("fill14_rts_n", rts_n, 1);
      end
      if (k == 15) begin
        check_val("fill16_full", full, 1);
        check_val("fill16_overrun", overrun, 0);
      end
    end
    check_val("ovr_level", level, 16);
    check_val("ovr_full", full, 1);
    check_val("ovr_flag", overrun, 1);
    check_val("ovr_rts_n", rts_n, 1);
    check_val("ovr_break", break_det, 0);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check_val("ovr_cleared", overrun, 0);
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      check_val("ovr_order", rxq.rx_data, 16 + k);
      pop();
    end
    check_val("ovr_drained", empty, 1);
    check_val("ovr_drained_vld", rxq.rx_valid, 0);

    // Break: line low for 12 bit times
    rx = 1'b0;
    repeat (12 * 16) wait_tick();
    rx = 1'b1;
    repeat (24 * 16) wait_tick();
    check_val("brk_flag", break_det, 1);
    check_val("brk_data", rxq.rx_data, 0);
    check_val("brk_ferr", rxq.rx_ferr, 1);
    check_val("brk_perr", rxq.rx_perr, 0);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check_val("brk_cleared", break_det, 0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check_val("brk_flushed", level, 0);

    // Flush while a frame is at data bit 3
    send_frame(9'h011, 8, 0, 1'b0, 1, 1'b0, -1, 1'b0);
    check_val("pre_flush_level", level, 1);
    send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b0, 3, 1'b1);
    check_val("post_flush_level", level, 1);
    check_val("post_flush_data", rxq.rx_data, 9'h03C);
    check_val("post_flush_ferr", rxq.rx_ferr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
